// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID hazard controller: RV32I major opcodes,
// the canonical NOP word, controller states and the register-use record.
package id_hazard_ctrl_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_ADDI = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01
  } state_e;

  typedef struct packed {
    logic       uses_rs1;
    logic       uses_rs2;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } reg_use_t;

endpackage

// File: rtl/id_hazard_ctrl_reg_use_decode.sv
// Combinational source-register usage decode of an RV32I instruction word;
// shared between hazard detection and forwarding.
module reg_use_decode
  import id_hazard_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output reg_use_t    use_o
);

  logic unused_bits;

  assign unused_bits = ^{instr[31:25], instr[14:7], instr[1:0]};

  always_comb begin
    use_o          = '0;
    use_o.rs1      = instr[19:15];
    use_o.rs2      = instr[24:20];
    unique case (instr[6:2])
      OPC_OP:                         begin use_o.uses_rs1 = 1'b1; use_o.uses_rs2 = 1'b1; end
      OPC_STORE, OPC_BRANCH:          begin use_o.uses_rs1 = 1'b1; use_o.uses_rs2 = 1'b1; end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: use_o.uses_rs1 = 1'b1;
      default:                        ;
    endcase
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// IF/ID pipeline-register controller: memory-busy freeze, load-use bubble,
// redirect flush with fetch-drain window, and a saturating stall counter.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 1,
  parameter logic [31:0] NOP_WORD     = NOP_ADDI
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_VALID,
  input  logic [31:0] IF_INSTR,
  input  logic [31:0] IF_PC,
  input  logic        IDEX_IS_LOAD,
  input  logic [4:0]  IDEX_RD,
  input  logic        MEM_BUSY,
  input  logic        REDIRECT,
  output logic        REDIRECT_ACK,
  output logic        PC_STALL,
  output logic [31:0] IFID_INSTR,
  output logic [31:0] IFID_PC,
  output logic        IFID_VALID,
  output logic        IDEX_BUBBLE,
  output logic [15:0] STALL_COUNT
);

  state_e      state_q, state_d;
  logic [2:0]  drain_q, drain_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  reg_use_t    ifid_use;
  logic        in_drain;
  logic        load_use;

  reg_use_decode u_reg_use_decode (
    .instr (ifid_instr_q),
    .use_o (ifid_use)
  );

  always_comb begin
    in_drain = (state_q == ST_DRAIN);
    load_use = ifid_valid_q && IDEX_IS_LOAD && (IDEX_RD != 5'd0) &&
               ((ifid_use.uses_rs1 && (ifid_use.rs1 == IDEX_RD)) ||
                (ifid_use.uses_rs2 && (ifid_use.rs2 == IDEX_RD)));
  end

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    drain_d      = drain_q;
    // Any non-DRAIN code, including unused encodings, resolves to RUN.
    state_d      = in_drain ? ST_DRAIN : ST_RUN;
    REDIRECT_ACK = 1'b0;
    PC_STALL     = 1'b0;
    IDEX_BUBBLE  = 1'b0;

    if (MEM_BUSY) begin
      PC_STALL = 1'b1;
    end else if (REDIRECT) begin
      REDIRECT_ACK = 1'b1;
      IDEX_BUBBLE  = 1'b1;
      ifid_instr_d = NOP_WORD;
      ifid_valid_d = 1'b0;
      drain_d      = 3'(DRAIN_CYCLES);
      state_d      = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_RUN;
    end else if (in_drain) begin
      ifid_instr_d = NOP_WORD;
      ifid_valid_d = 1'b0;
      if (drain_q <= 3'd1) begin
        drain_d = '0;
        state_d = ST_RUN;
      end else begin
        drain_d = drain_q - 3'd1;
      end
    end else if (load_use) begin
      PC_STALL    = 1'b1;
      IDEX_BUBBLE = 1'b1;
    end else if (IF_VALID) begin
      ifid_instr_d = IF_INSTR;
      ifid_pc_d    = IF_PC;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_instr_d = NOP_WORD;
      ifid_valid_d = 1'b0;
    end

    stall_cnt_d = (PC_STALL && (stall_cnt_q != '1)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_RUN;
      drain_q      <= '0;
      ifid_instr_q <= NOP_WORD;
      ifid_pc_q    <= RESET_PC;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_comb begin
    IFID_INSTR  = ifid_instr_q;
    IFID_PC     = ifid_pc_q;
    IFID_VALID  = ifid_valid_q;
    STALL_COUNT = stall_cnt_q;
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: directed per-cycle vectors push their
// expected outputs; a negedge monitor pops and compares.
module tb_id_hazard_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IF_VALID = 1'b0;
  logic [31:0] IF_INSTR = '0;
  logic [31:0] IF_PC = '0;
  logic        IDEX_IS_LOAD = 1'b0;
  logic [4:0]  IDEX_RD = '0;
  logic        MEM_BUSY = 1'b0;
  logic        REDIRECT = 1'b0;
  logic        REDIRECT_ACK, PC_STALL, IFID_VALID, IDEX_BUBBLE;
  logic [31:0] IFID_INSTR, IFID_PC;
  logic [15:0] STALL_COUNT;

  always #5 CLK = ~CLK;

  id_hazard_ctrl #(
    .RESET_PC     (RST_PC),
    .DRAIN_CYCLES (2)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .IF_VALID     (IF_VALID),
    .IF_INSTR     (IF_INSTR),
    .IF_PC        (IF_PC),
    .IDEX_IS_LOAD (IDEX_IS_LOAD),
    .IDEX_RD      (IDEX_RD),
    .MEM_BUSY     (MEM_BUSY),
    .REDIRECT     (REDIRECT),
    .REDIRECT_ACK (REDIRECT_ACK),
    .PC_STALL     (PC_STALL),
    .IFID_INSTR   (IFID_INSTR),
    .IFID_PC      (IFID_PC),
    .IFID_VALID   (IFID_VALID),
    .IDEX_BUBBLE  (IDEX_BUBBLE),
    .STALL_COUNT  (STALL_COUNT)
  );

  typedef struct {
    string       nm;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        chk_pc;
    logic        ack;
    logic        stall;
    logic        bub;
    logic [15:0] cnt;
    logic        chk;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic cpc, input logic a, input logic s, input logic b, input logic c);
    exp_t e;
    e.nm = nm; e.valid = v; e.instr = ins; e.pc = pc; e.chk_pc = cpc;
    e.ack = a; e.stall = s; e.bub = b; e.cnt = exp_cnt; e.chk = c;
    sb.push_back(e);
    if (s && exp_cnt != 16'hFFFF) exp_cnt++;
  endtask

  // Drive one cycle of inputs and queue what the DUT must show during it.
  task automatic step(input string nm, input logic ifv, input logic [31:0] ins, input logic [31:0] ipc,
                      input logic ld, input logic [4:0] rd, input logic busy, input logic redir,
                      input logic ev, input logic [31:0] eins, input logic [31:0] epc,
                      input logic ea, input logic es, input logic eb, input logic c);
    @(posedge CLK); #1;
    RST = 1'b0; IF_VALID = ifv; IF_INSTR = ins; IF_PC = ipc;
    IDEX_IS_LOAD = ld; IDEX_RD = rd; MEM_BUSY = busy; REDIRECT = redir;
    push(nm, ev, eins, epc, ev, ea, es, eb, c);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) begin
          chk(e.nm, "valid", {31'b0, IFID_VALID}, {31'b0, e.valid});
          chk(e.nm, "instr", IFID_INSTR, e.instr);
          if (e.chk_pc) chk(e.nm, "pc", IFID_PC, e.pc);
          chk(e.nm, "ack", {31'b0, REDIRECT_ACK}, {31'b0, e.ack});
          chk(e.nm, "pc_stall", {31'b0, PC_STALL}, {31'b0, e.stall});
          chk(e.nm, "bubble", {31'b0, IDEX_BUBBLE}, {31'b0, e.bub});
          chk(e.nm, "count", {16'b0, STALL_COUNT}, {16'b0, e.cnt});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    push("reset", 1'b0, NOP, RST_PC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    //    name            ifv  instr          pc        ld   rd    busy redir | ev   instr          pc        ack  stall bub  chk
    step("norm_fill",     1, 32'h00500093, 32'h100,  0, 5'd0, 0, 0,   0, NOP,           32'h0,   0, 0, 0, 1);
    step("norm_load",     1, 32'h002081B3, 32'h104,  0, 5'd0, 0, 0,   1, 32'h00500093,  32'h100, 0, 0, 0, 1);
    step("lu_rs1",        1, 32'h00C00213, 32'h108,  1, 5'd1, 0, 0,   1, 32'h002081B3,  32'h104, 0, 1, 1, 1);
    step("lu_release",    1, 32'h002001B3, 32'h10C,  0, 5'd0, 0, 0,   1, 32'h002081B3,  32'h104, 0, 0, 0, 1);
    step("lu_rd0",        1, 32'h000081B7, 32'h110,  1, 5'd0, 0, 0,   1, 32'h002001B3,  32'h10C, 0, 0, 0, 1);
    step("lu_lui",        1, 32'h002081B3, 32'h114,  1, 5'd1, 0, 0,   1, 32'h000081B7,  32'h110, 0, 0, 0, 1);
    step("lu_rs2",        1, 32'h00500093, 32'h118,  1, 5'd2, 0, 0,   1, 32'h002081B3,  32'h114, 0, 1, 1, 1);
    step("lu_rs2_rel",    1, 32'h00500093, 32'h118,  0, 5'd0, 0, 0,   1, 32'h002081B3,  32'h114, 0, 0, 0, 1);
    step("redirect",      1, 32'h00000033, 32'h11C,  0, 5'd0, 0, 1,   1, 32'h00500093,  32'h118, 1, 0, 1, 1);
    step("flush",         1, 32'h00000033, 32'h200,  0, 5'd0, 0, 0,   0, NOP,           32'h0,   0, 0, 0, 1);
    step("drain1",        1, 32'h00000033, 32'h200,  0, 5'd0, 0, 0,   0, NOP,           32'h0,   0, 0, 0, 1);
    step("drain2",        1, 32'h00100113, 32'h204,  0, 5'd0, 0, 0,   0, NOP,           32'h0,   0, 0, 0, 1);
    step("busy_redir_a",  1, 32'h00200193, 32'h208,  0, 5'd0, 1, 1,   1, 32'h00100113,  32'h204, 0, 1, 0, 1);
    step("busy_redir_b",  1, 32'h00200193, 32'h208,  0, 5'd0, 1, 1,   1, 32'h00100113,  32'h204, 0, 1, 0, 1);
    step("busy_redir_c",  1, 32'h00200193, 32'h208,  0, 5'd0, 1, 1,   1, 32'h00100113,  32'h204, 0, 1, 0, 1);
    step("redir_ack",     1, 32'h00200193, 32'h208,  0, 5'd0, 0, 1,   1, 32'h00100113,  32'h204, 1, 0, 1, 1);
    step("redir_in_drn",  1, 32'h00000033, 32'h300,  0, 5'd0, 0, 1,   0, NOP,           32'h0,   1, 0, 1, 1);
    step("reload1",       1, 32'h00000033, 32'h300,  0, 5'd0, 0, 0,   0, NOP,           32'h0,   0, 0, 0, 1);
    step("reload2",       1, 32'h00000033, 32'h300,  0, 5'd0, 0, 0,   0, NOP,           32'h0,   0, 0, 0, 1);
    step("resume",        1, 32'h00300213, 32'h300,  0, 5'd0, 0, 0,   0, NOP,           32'h0,   0, 0, 0, 1);
    step("resume_chk",    0, 32'h0,        32'h0,    0, 5'd0, 0, 0,   1, 32'h00300213,  32'h300, 0, 0, 0, 1);
    step("if_idle_busy",  0, 32'h0,        32'h0,    0, 5'd0, 1, 0,   0, NOP,           32'h0,   0, 1, 0, 1);

    for (int i = 0; i < 65540; i++)
      step("sat", 0, 32'h0, 32'h0, 0, 5'd0, 1, 0, 0, NOP, 32'h0, 0, 1, 0, (exp_cnt >= 16'hFFFC));
    step("sat_hold",      0, 32'h0,        32'h0,    0, 5'd0, 1, 0,   0, NOP,           32'h0,   0, 1, 0, 1);
    step("sat_release",   1, 32'h00700393, 32'h400,  0, 5'd0, 0, 0,   0, NOP,           32'h0,   0, 0, 0, 1);
    step("pre_reset",     1, 32'h00800413, 32'h404,  0, 5'd0, 0, 0,   1, 32'h00700393,  32'h400, 0, 0, 0, 1);

    // Reset raised mid-cycle: the monitor sees it before the next rising edge.
    @(posedge CLK); #1;
    RST = 1'b1; IF_VALID = 1'b1; IF_INSTR = 32'h00900493; IF_PC = 32'h408;
    IDEX_IS_LOAD = 1'b0; MEM_BUSY = 1'b0; REDIRECT = 1'b0;
    exp_cnt = '0;
    push("async_rst", 1'b0, NOP, RST_PC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    step("rst_release",   1, 32'h00A00513, 32'h40C,  0, 5'd0, 0, 0,   0, NOP,           32'h0,   0, 0, 0, 1);
    step("post_rst",      0, 32'h0,        32'h0,    0, 5'd0, 0, 0,   1, 32'h00A00513,  32'h40C, 0, 0, 0, 1);

    @(negedge CLK); #1;
    chk("end", "sb_left", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
IF/ID pipeline-register controller for the pipelined RV32I core. It owns the IF/ID register that feeds the decode stage (instruction decode and immediate generation), and it sequences that register.
- Freeze on data-memory busy.
- Single-bubble stall on load-use hazards.
- Flush plus a fetch-drain window on EX-stage redirects (taken branch, JAL, JALR).
- NOP injection into ID/EX, and a saturating stall counter for performance monitoring.

Parameters:
RESET_PC, 32'h0000_0000, value of IFID_PC after reset
DRAIN_CYCLES, 1, number of cycles after an accepted redirect during which IF_VALID is ignored (instruction-memory latency); legal range 0..7
NOP_WORD, 32'h0000_0013, instruction word injected on bubble/flush (addi x0,x0,0)

Ports:
CLK  in  1  core clock, rising edge
RST  in  1  asynchronous, active-high reset
IF_VALID  in  1  fetch stage presents a valid instruction
IF_INSTR  in  32  fetched instruction
IF_PC  in  32  PC of fetched instruction
IDEX_IS_LOAD  in  1  instruction currently in EX is a load
IDEX_RD  in  5  destination register of instruction in EX
MEM_BUSY  in  1  data memory not ready; whole front end freezes
REDIRECT  in  1  EX requests flush (taken branch/jump); held until acknowledged
REDIRECT_ACK  out  1  redirect accepted this cycle (combinational)
PC_STALL  out  1  fetch PC must hold this cycle (combinational)
IFID_INSTR  out  32  registered instruction to decode
IFID_PC  out  32  registered PC to decode
IFID_VALID  out  1  IFID contents valid
IDEX_BUBBLE  out  1  ID/EX must load a NOP this cycle (combinational)
STALL_COUNT  out  16  saturating count of PC_STALL cycles

Behaviour:
Reset (async, RST=1):
- IFID_INSTR=NOP_WORD, IFID_PC=RESET_PC, IFID_VALID=0.
- STALL_COUNT=0, drain counter=0, state=RUN.

Decode of IFID_INSTR (opcode bits [6:2]):
- uses_rs1 for OP, OP_IMM, LOAD, STORE, BRANCH, JALR.
- uses_rs2 for OP, STORE, BRANCH.
- rs1=[19:15], rs2=[24:20].

Load-use hazard:
- lu = IFID_VALID & IDEX_IS_LOAD & (IDEX_RD!=0) & ((uses_rs1 & rs1==IDEX_RD) | (uses_rs2 & rs2==IDEX_RD)).

Per-cycle priority, highest first:
1. MEM_BUSY=1:
   - IFID holds.
   - PC_STALL=1, IDEX_BUBBLE=0 (ID/EX also frozen downstream).
   - REDIRECT_ACK=0.
   - Drain counter holds.
2. REDIRECT=1:
   - REDIRECT_ACK=1.
   - IFID loads NOP_WORD with VALID=0; IDEX_BUBBLE=1; PC_STALL=0 (PC takes the target).
   - Drain counter loads DRAIN_CYCLES; state goes to DRAIN if DRAIN_CYCLES>0, else RUN.
3. State DRAIN:
   - IF_VALID is ignored; IFID loads NOP with VALID=0.
   - Counter decrements; at 1 -> 0 go to RUN.
   - A new REDIRECT in DRAIN reloads the counter.
4. lu=1:
   - IFID holds; PC_STALL=1; IDEX_BUBBLE=1.
   - Lasts exactly one cycle, because the next cycle's EX holds the bubble and IDEX_IS_LOAD drops.
5. Normal:
   - If IF_VALID, IFID loads IF_INSTR/IF_PC with VALID=1.
   - Otherwise IFID loads NOP with VALID=0.

Timing and counter:
- Latency: IF to IFID is 1 cycle.
- REDIRECT_ACK, PC_STALL and IDEX_BUBBLE are combinational from the current inputs and state.
- STALL_COUNT increments on each cycle with PC_STALL=1 and saturates at 16'hFFFF (no wrap).

States:
- RUN and DRAIN only. The encoding has 2 bits; unused codes go to RUN.
- RST asserted mid-drain or mid-stall returns to reset values immediately.

Decomposition:
- Shared package/header:
  - 5-bit opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
  - NOP_WORD.
  - State encodings.
- One natural sub-module: `reg_use_decode`, combinational INSTR -> {uses_rs1, uses_rs2, rs1, rs2}. It is reusable by the forwarding unit.

Test Plan:
- Reset: RST=1 mid-run -> IFID_VALID=0, IFID_INSTR=0x00000013, IFID_PC=RESET_PC, STALL_COUNT=0, all asynchronously before the next edge.
- Normal flow: IF_VALID=1, IF_INSTR=0x00500093, IF_PC=0x100 -> next cycle IFID_INSTR=0x00500093, IFID_PC=0x100, VALID=1; PC_STALL=0.
- Load-use:
  - Setup: IFID=add x3,x1,x2 (0x002081B3); IDEX_IS_LOAD=1, IDEX_RD=1.
  - Expected: PC_STALL=1 and IDEX_BUBBLE=1 for exactly 1 cycle, and IFID unchanged.
  - Repeat with IDEX_RD=0 -> no stall.
  - Repeat with IFID=lui x3 -> no stall.
- Redirect with DRAIN_CYCLES=2:
  - REDIRECT=1 for 1 cycle -> REDIRECT_ACK=1 and IDEX_BUBBLE=1.
  - IFID_VALID=0 for 3 cycles (flush cycle + 2 drain cycles) even though IF_VALID=1.
  - Valid fetches resume on the 4th cycle.
- MEM_BUSY vs REDIRECT: both asserted for 3 cycles, then MEM_BUSY drops -> REDIRECT_ACK=0 for 3 cycles and IFID frozen, then ACK=1 in cycle 4.
- Counter saturation: preload via 65540 stall cycles -> STALL_COUNT=16'hFFFF, then holds on further stalls.
